serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 164 ++++++++++++++++
 tb/tb_serial_add_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_add_seq : bit-serial {Cout,Sum} = A + B + Cin, LSB first, one full adder.
// Optional Overflow output enabled by macro SERIAL_ADD_OVF_EN.   Rev 1.0
// ---------------------------------------------------------------------------

module adder_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  if (IMPL_TYPE == 0) begin : g_xor_mux
    logic w_p;
    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = w_p ? ci : a;
  end else begin : g_maj_not
    logic w_inner;
    assign co      = (a & b) | (a & ci) | (b & ci);
    // s = MAJ(~co, ci, MAJ(a, b, ~ci))
    assign w_inner = (a & b) | (a & ~ci) | (b & ~ci);
    assign s       = (~co & ci) | (~co & w_inner) | (ci & w_inner);
  end
endmodule

module serial_add_seq #(
  parameter int WIDTH     = 8,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             Overflow,
`endif
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             live_q;
  logic             bit_sum, bit_carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_add (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (bit_sum),
    .co (bit_carry)
  );

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready  = live_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign Overflow  = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && live_q) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
        carry_d = bit_carry;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = bit_carry;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ bit_carry;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      live_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      live_q  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_add_seq : drives both IMPL_TYPE variants of serial_add_seq in lockstep.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_add_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic         busy0, busy1, cout0, cout1;
  logic [W-1:0] sum0, sum1;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf0, ovf1;
`endif

  serial_add_seq #(.WIDTH(W), .IMPL_TYPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
    .Sum(sum0), .Cout(cout0),
`ifdef SERIAL_ADD_OVF_EN
    .Overflow(ovf0),
`endif
    .busy(busy0)
  );

  serial_add_seq #(.WIDTH(W), .IMPL_TYPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .Sum(sum1), .Cout(cout1),
`ifdef SERIAL_ADD_OVF_EN
    .Overflow(ovf1),
`endif
    .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  res_t sb[$];
  vec_t tbl[7];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t r;
    logic [W:0]   full;
    logic [W-1:0] low;
    full   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    low    = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(c);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = low[W-1] ^ full[W];
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting on DUT at %0t", nm, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic ir, input logic ov, input logic bz);
    check({tag, " in_ready0"}, 64'(in_ready0), 64'(ir));
    check({tag, " in_ready1"}, 64'(in_ready1), 64'(ir));
    check({tag, " out_valid0"}, 64'(out_valid0), 64'(ov));
    check({tag, " out_valid1"}, 64'(out_valid1), 64'(ov));
    check({tag, " busy0"}, 64'(busy0), 64'(bz));
    check({tag, " busy1"}, 64'(busy1), 64'(bz));
  endtask

  task automatic chk_outs(input string tag, input res_t e);
    check({tag, " sum0"}, 64'(sum0), 64'(e.sum));
    check({tag, " sum1"}, 64'(sum1), 64'(e.sum));
    check({tag, " cout0"}, 64'(cout0), 64'(e.cout));
    check({tag, " cout1"}, 64'(cout1), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, " ovf0"}, 64'(ovf0), 64'(e.ovf));
    check({tag, " ovf1"}, 64'(ovf1), 64'(e.ovf));
`endif
  endtask

  task automatic check_result(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      fail_timeout({tag, " scoreboard empty"});
    end else begin
      e = sb.pop_front();
      chk_outs(tag, e);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(in_ready0 && in_ready1) && n < 50) begin
      tick;
      n++;
    end
    if (!(in_ready0 && in_ready1)) fail_timeout({tag, " in_ready"});
  endtask

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input res_t e);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
    sb.push_back(e);
    tick;
  endtask

  task automatic await_done(input string tag);
    int lat = 0;
    int bz = 0;
    while (!out_valid0 && lat < W + 10) begin
      if (busy0 && busy1) bz++;
      tick;
      lat++;
    end
    if (!out_valid0) fail_timeout({tag, " out_valid"});
    check({tag, " latency"}, 64'(lat), 64'(W));
    check({tag, " busy cycles"}, 64'(bz), 64'(W));
    check({tag, " out_valid1"}, 64'(out_valid1), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input res_t e);
    wait_ready(tag);
    accept(x, y, c, e);
    in_valid = 1'b0;
    await_done(tag);
    out_ready = 1'b1;
    check_result(tag);
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    res_t z;
    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    z = '{8'h00, 1'b0, 1'b0};

    // Reset values, then in_ready rises on the first edge after release
    #1;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
    chk_outs("reset", z);
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    check("post-release in_ready0", 64'(in_ready0), 64'd0);
    tick;
    chk_ctrl("first edge", 1'b1, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      e = '{tbl[i].sum, tbl[i].cout, tbl[i].ovf};
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, e);
    end

    // Reset in the middle of RUN discards the operation
    wait_ready("midrst");
    accept(8'h3C, 8'h5A, 1'b0, model(8'h3C, 8'h5A, 1'b0));
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk_ctrl("midrst", 1'b0, 1'b0, 1'b0);
    chk_outs("midrst", z);
    sb.delete();
    tick;
    rst_n = 1'b1;
    tick;
    run_op("after rst", 8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0});

    // DONE holds while out_ready is low; in_valid pulses are ignored
    wait_ready("hold");
    e = model(8'hA5, 8'h3C, 1'b1);
    accept(8'hA5, 8'h3C, 1'b1, e);
    in_valid = 1'b0;
    await_done("hold");
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid;
      a = 8'(k * 37 + 5);
      b = 8'(k * 11 + 3);
      tick;
      chk_ctrl($sformatf("hold%0d", k), 1'b0, 1'b1, 1'b0);
      chk_outs($sformatf("hold%0d", k), e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_result("hold final");
    tick;
    out_ready = 1'b0;
    chk_ctrl("hold exit", 1'b1, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      wait_ready("b2b");
      accept(ra, rb, rc, model(ra, rb, rc));
      await_done("b2b");
      check_result("b2b");
      tick;
      check("b2b next in_ready0", 64'(in_ready0), 64'd1);
      check("b2b next in_ready1", 64'(in_ready1), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
